// File: rtl/fsm_ex_pkg.sv
// Shared constants for the exposure-control FSM: main and readout state
// encodings, timer width and the active levels of the pixel strobes.
package fsm_ex_pkg;

    localparam int COUNT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_EXPOSURE = 2'b01,
        S_READOUT  = 2'b10
    } main_state_e;

    // Encoding of the external readout sub-FSM, observed on i_RD_FSM.
    typedef enum logic [2:0] {
        RD_INIT = 3'b000,
        NRE_1   = 3'b001,
        ADC_1   = 3'b010,
        NOTHING = 3'b011,
        NRE_2   = 3'b100,
        ADC_2   = 3'b101,
        END     = 3'b110
    } rd_state_e;

    localparam logic NRE_ACTIVE    = 1'b0;
    localparam logic ADC_ACTIVE    = 1'b1;
    localparam logic EXPOSE_ACTIVE = 1'b1;
    localparam logic ERASE_ACTIVE  = 1'b1;

endpackage

// File: rtl/fsm_ex_control_if.sv
// Control bus between the exposure FSM and its surroundings: timer and
// readout-FSM status in, pixel strobes and main-state export out.
interface fsm_ex_control_if;
    import fsm_ex_pkg::*;

    logic               i_Init;
    logic [COUNT_W-1:0] i_count_time;
    logic [2:0]         i_RD_FSM;
    logic               o_NRE_1;
    logic               o_NRE_2;
    logic               o_ADC;
    logic               o_Expose;
    logic               o_Erase;
    logic [1:0]         o_Main_FSM;

    modport master (
        output i_Init, i_count_time, i_RD_FSM,
        input  o_NRE_1, o_NRE_2, o_ADC, o_Expose, o_Erase, o_Main_FSM
    );

    modport slave (
        input  i_Init, i_count_time, i_RD_FSM,
        output o_NRE_1, o_NRE_2, o_ADC, o_Expose, o_Erase, o_Main_FSM
    );

endinterface

// File: rtl/fsm_ex_readout_decode.sv
// Combinational map from the readout sub-state to the NRE/ADC strobes,
// forced inactive whenever the main FSM is not in READOUT.
module fsm_ex_readout_decode
    import fsm_ex_pkg::*;
(
    input  logic       enable,
    input  logic [2:0] rd_state,
    output logic       nre_1,
    output logic       nre_2,
    output logic       adc
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        nre_1 = ~NRE_ACTIVE;
        nre_2 = ~NRE_ACTIVE;
        adc   = ~ADC_ACTIVE;
        if (enable) begin
            case (rd_state)
                NRE_1: nre_1 = NRE_ACTIVE;
                ADC_1: begin
                    nre_1 = NRE_ACTIVE;
                    adc   = ADC_ACTIVE;
                end
                NRE_2: nre_2 = NRE_ACTIVE;
                ADC_2: begin
                    nre_2 = NRE_ACTIVE;
                    adc   = ADC_ACTIVE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fsm_ex_control.sv
// Top-level exposure-control FSM: IDLE (erase) -> EXPOSURE -> READOUT,
// driven by the external exposure timer and readout sub-FSM.
module fsm_ex_control
    import fsm_ex_pkg::*;
(
    input  logic              i_Clock,
    input  logic              i_Reset,
    fsm_ex_control_if.slave   bus
);

    main_state_e state;

    always_ff @(posedge i_Clock) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!i_Reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:     if (bus.i_Init) state <= S_EXPOSURE;
                S_EXPOSURE: if (bus.i_count_time == '0) state <= S_READOUT;
                S_READOUT:  if (bus.i_RD_FSM == END) state <= S_IDLE;
                default:    state <= S_IDLE;
            endcase
        end
    end

    // The illegal encoding 2'b11 decodes like IDLE: erase asserted.
    assign bus.o_Erase    = (state == S_EXPOSURE || state == S_READOUT)
                            ? ~ERASE_ACTIVE : ERASE_ACTIVE;
    assign bus.o_Expose   = (state == S_EXPOSURE) ? EXPOSE_ACTIVE : ~EXPOSE_ACTIVE;
    assign bus.o_Main_FSM = state;

    fsm_ex_readout_decode u_readout_decode (
        .enable   (state == S_READOUT),
        .rd_state (bus.i_RD_FSM),
        .nre_1    (bus.o_NRE_1),
        .nre_2    (bus.o_NRE_2),
        .adc      (bus.o_ADC)
    );

endmodule

// File: tb/tb_fsm_ex_control.sv
// Directed bench for fsm_ex_control; output vector compared is
// {o_Main_FSM, o_Erase, o_Expose, o_NRE_1, o_NRE_2, o_ADC}.
module tb_fsm_ex_control;
    import fsm_ex_pkg::*;

    logic i_Clock;
    logic i_Reset;
    int   test_count;
    int   fail_count;

    fsm_ex_control_if bus ();

    fsm_ex_control dut (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .bus     (bus)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    localparam logic [6:0] V_IDLE = 7'b00_1_0_110;
    localparam logic [6:0] V_EXP  = 7'b01_0_1_110;

    function automatic logic [6:0] v_ro(input logic [2:0] strobes);
        return {2'b10, 1'b0, 1'b0, strobes};
    endfunction

    function automatic logic [6:0] observed();
        return {bus.o_Main_FSM, bus.o_Erase, bus.o_Expose,
                bus.o_NRE_1, bus.o_NRE_2, bus.o_ADC};
    endfunction

    task automatic step();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [6:0] expected);
        logic [6:0] obs;
        obs = observed();
        test_count++;
        assert (obs === expected) else begin
            fail_count++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expected);
        end
    endtask

    logic [2:0] walk_rd  [9] = '{RD_INIT, NRE_1, ADC_1, NRE_1, NOTHING,
                                 NRE_2, ADC_2, NRE_2, 3'b111};
    logic [2:0] walk_exp [9] = '{3'b110, 3'b010, 3'b011, 3'b010, 3'b110,
                                 3'b100, 3'b101, 3'b100, 3'b110};

    initial begin
        test_count       = 0;
        fail_count       = 0;
        i_Reset          = 1'b0;
        bus.i_Init       = 1'b1;
        bus.i_count_time = 5'd30;
        bus.i_RD_FSM     = RD_INIT;

        // Reset dominates a held i_Init.
        step();
        check("reset_1", V_IDLE);
        step();
        check("reset_2", V_IDLE);

        // Start exposure with a one-clock i_Init pulse.
        i_Reset = 1'b1;
        step();
        bus.i_Init = 1'b0;
        check("enter_exposure", V_EXP);
        step();
        check("exposure_hold_1", V_EXP);
        bus.i_RD_FSM = ADC_1;
        #1;
        check("exposure_ignores_rd", V_EXP);
        bus.i_RD_FSM = RD_INIT;
        step();
        check("exposure_hold_2", V_EXP);

        // Timer expiry moves to readout.
        bus.i_count_time = 5'd0;
        step();
        check("enter_readout", v_ro(3'b110));

        for (int i = 0; i < 9; i++) begin
            bus.i_RD_FSM = walk_rd[i];
            #1;
            check($sformatf("rd_walk_%0d", i), v_ro(walk_exp[i]));
            if (i == 4) bus.i_Init = 1'b1;
            step();
            bus.i_Init = 1'b0;
            check($sformatf("rd_stay_%0d", i), v_ro(walk_exp[i]));
        end

        // END strobes inactive, then back to IDLE.
        bus.i_RD_FSM = END;
        #1;
        check("rd_end_strobes", v_ro(3'b110));
        step();
        check("readout_to_idle", V_IDLE);
        step();
        check("idle_hold", V_IDLE);

        // Restart with count already 0: exposure still lasts one clock.
        bus.i_Init   = 1'b1;
        bus.i_RD_FSM = RD_INIT;
        step();
        bus.i_Init = 1'b0;
        check("restart_exposure", V_EXP);
        step();
        check("min_dwell_readout", v_ro(3'b110));

        // Reset mid-READOUT while ADC_1 is active.
        bus.i_RD_FSM = ADC_1;
        #1;
        check("readout_adc1", v_ro(3'b011));
        i_Reset = 1'b0;
        step();
        check("reset_in_readout", V_IDLE);

        // Reset mid-EXPOSURE.
        i_Reset          = 1'b1;
        bus.i_Init       = 1'b1;
        bus.i_count_time = 5'd30;
        step();
        bus.i_Init = 1'b0;
        check("exposure_again", V_EXP);
        i_Reset = 1'b0;
        step();
        check("reset_in_exposure", V_IDLE);
        i_Reset = 1'b1;
        step();
        check("idle_after_reset", V_IDLE);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
